inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of fetch-packet entries (power of two).
REQ-002 SHALL have port Clk  input  1  core clock; all state changes on the rising edge.
REQ-003 SHALL have port Rest  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port InFetchValid  input  1  fetch offers a packet this cycle.
REQ-005 SHALL have port InFetchPc  input  `InstAddrBus (32)  PC of slot 1 of the offered packet.
REQ-006 SHALL have ports InFetchInst1..InFetchInst4  input  `InstDateBus (32) each  packet instruction slots 1-4.
REQ-007 SHALL have port InFetchMask  input  4  per-slot valid bits; bit0 = slot 1.
REQ-008 SHALL have port OutFetchReady  output  1  queue can accept a packet.
REQ-009 SHALL have port InFlush  input  1  pipeline flush (branch mispredict or exception).
REQ-010 SHALL have port OutDecodeValid  output  1  head packet presented to decode.
REQ-011 SHALL have port OutDecodePc  output  `InstAddrBus (32)  head packet PC.
REQ-012 SHALL have ports OutDecodeInst1..OutDecodeInst4  output  `InstDateBus (32) each  head packet instructions.
REQ-013 SHALL have port OutDecodeMask  output  4  head packet slot valid bits.
REQ-014 SHALL have port InDecodeReady  input  1  decode accepts the head packet.
REQ-015 SHALL have port OutQueueCount  output  log2(DEPTH)+1  occupied entries.

Function
REQ-016 SHALL store whole packets (PC, four instructions, mask) in a circular buffer of DEPTH entries with read pointer, write pointer and occupancy count.
REQ-017 SHALL assert OutFetchReady exactly when count < DEPTH (no full-queue bypass, independent of same-cycle pop).
REQ-018 SHALL push when InFetchValid & OutFetchReady & (InFetchMask != 0): write entry at write pointer, increment write pointer modulo DEPTH.
REQ-019 SHALL silently drop an offered packet with InFetchMask == 4'b0000 (no write, no count change).
REQ-020 SHALL assert OutDecodeValid exactly when count != 0.
REQ-021 SHALL drive OutDecodePc/Inst1..4/Mask from the entry at the read pointer while OutDecodeValid=1, and all zeros while OutDecodeValid=0.
REQ-022 SHALL pop when OutDecodeValid & InDecodeReady: increment read pointer modulo DEPTH.
REQ-023 SHALL make a pushed packet visible at the decode outputs no earlier than the cycle after the push edge (1-cycle latency, no empty bypass).
REQ-024 SHALL update count as +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-025 SHALL hold head outputs stable while OutDecodeValid=1 and InDecodeReady=0.
REQ-026 SHALL, on InFlush=1 at a rising edge, set read pointer, write pointer and count to 0, overriding any same-cycle push and pop.
REQ-027 SHALL ignore InFetchValid and InDecodeReady for state update during a flush cycle; OutFetchReady and OutDecodeValid reflect pre-flush state during that cycle.
REQ-028 SHALL wrap both pointers from DEPTH-1 to 0 with no data loss.
REQ-029 SHALL never overflow or underflow the count under any input combination.

Reset
REQ-030 SHALL, while Rest=1, asynchronously clear pointers and count to 0, drive OutFetchReady=1, OutDecodeValid=0, OutQueueCount=0 and all decode data outputs to 0.
REQ-031 SHALL need no clearing of storage array contents on reset.
REQ-032 SHALL discard any in-flight push or pop when Rest asserts mid-operation; first push after deassertion lands in entry 0.

Verification
REQ-033 SHALL pass: reset, push one packet Pc=0x1C000000, Inst1..4=0x11,0x22,0x33,0x44, mask 4'b1111 -> next cycle OutDecodeValid=1, OutDecodePc=0x1C000000, OutQueueCount=1.
REQ-034 SHALL pass: 8 pushes with InDecodeReady=0 -> OutFetchReady=0 after 8th, count=8; 9th offer not stored; one pop -> OutFetchReady=1, count=7.
REQ-035 SHALL pass: count=3, push and pop same cycle -> count stays 3, head advances to 2nd packet.
REQ-036 SHALL pass: count=5, InFlush=1 with InFetchValid=1 and InDecodeReady=1 -> next cycle count=0, OutDecodeValid=0, OutFetchReady=1.
REQ-037 SHALL pass: 20 packets Pc=0x1C000000+16*i streamed with random InDecodeReady -> all popped in order with matching data across pointer wrap.
REQ-038 SHALL pass: push with mask 4'b0000 -> count unchanged; then mask 4'b0011 -> OutDecodeMask=4'b0011 next cycle.

Source files
------------

// File: rtl/inst_queue.sv
// Fetch-packet queue between fetch and decode: circular buffer of whole packets
// (PC, four instruction slots, slot mask) with registered head presentation.
module inst_queue #(
    parameter int DEPTH = 8  // power of two, >= 2
) (
    input  logic                       Clk,
    input  logic                       Rest,
    input  logic                       InFetchValid,
    input  logic [31:0]                InFetchPc,
    input  logic [31:0]                InFetchInst1,
    input  logic [31:0]                InFetchInst2,
    input  logic [31:0]                InFetchInst3,
    input  logic [31:0]                InFetchInst4,
    input  logic [3:0]                 InFetchMask,
    output logic                       OutFetchReady,
    input  logic                       InFlush,
    output logic                       OutDecodeValid,
    output logic [31:0]                OutDecodePc,
    output logic [31:0]                OutDecodeInst1,
    output logic [31:0]                OutDecodeInst2,
    output logic [31:0]                OutDecodeInst3,
    output logic [31:0]                OutDecodeInst4,
    output logic [3:0]                 OutDecodeMask,
    input  logic                       InDecodeReady,
    output logic [$clog2(DEPTH):0]     OutQueueCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] inst1_mem [DEPTH];
    logic [31:0] inst2_mem [DEPTH];
    logic [31:0] inst3_mem [DEPTH];
    logic [31:0] inst4_mem [DEPTH];
    logic [3:0]  mask_mem  [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign OutFetchReady  = count < FULL;
    assign OutDecodeValid = count != '0;
    assign OutQueueCount  = count;

    // Flush wins over everything; empty-mask packets are dropped without a write.
    assign push = InFetchValid & OutFetchReady & (InFetchMask != 4'b0000) & ~InFlush;
    assign pop  = OutDecodeValid & InDecodeReady & ~InFlush;

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (InFlush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge Clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= InFetchPc;
            inst1_mem[wr_ptr] <= InFetchInst1;
            inst2_mem[wr_ptr] <= InFetchInst2;
            inst3_mem[wr_ptr] <= InFetchInst3;
            inst4_mem[wr_ptr] <= InFetchInst4;
            mask_mem[wr_ptr]  <= InFetchMask;
        end
    end

    always_comb begin
        OutDecodePc    = '0;
        OutDecodeInst1 = '0;
        OutDecodeInst2 = '0;
        OutDecodeInst3 = '0;
        OutDecodeInst4 = '0;
        OutDecodeMask  = '0;
        if (OutDecodeValid) begin
            OutDecodePc    = pc_mem[rd_ptr];
            OutDecodeInst1 = inst1_mem[rd_ptr];
            OutDecodeInst2 = inst2_mem[rd_ptr];
            OutDecodeInst3 = inst3_mem[rd_ptr];
            OutDecodeInst4 = inst4_mem[rd_ptr];
            OutDecodeMask  = mask_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-of-packets reference model.
module tb_inst_queue;

    localparam int DEPTH = 8;

    logic        Clk = 1'b0;
    logic        Rest;
    logic        InFetchValid;
    logic [31:0] InFetchPc, InFetchInst1, InFetchInst2, InFetchInst3, InFetchInst4;
    logic [3:0]  InFetchMask;
    logic        OutFetchReady;
    logic        InFlush;
    logic        OutDecodeValid;
    logic [31:0] OutDecodePc, OutDecodeInst1, OutDecodeInst2, OutDecodeInst3, OutDecodeInst4;
    logic [3:0]  OutDecodeMask;
    logic        InDecodeReady;
    logic [3:0]  OutQueueCount;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rest(Rest),
        .InFetchValid(InFetchValid), .InFetchPc(InFetchPc),
        .InFetchInst1(InFetchInst1), .InFetchInst2(InFetchInst2),
        .InFetchInst3(InFetchInst3), .InFetchInst4(InFetchInst4),
        .InFetchMask(InFetchMask), .OutFetchReady(OutFetchReady),
        .InFlush(InFlush), .OutDecodeValid(OutDecodeValid),
        .OutDecodePc(OutDecodePc),
        .OutDecodeInst1(OutDecodeInst1), .OutDecodeInst2(OutDecodeInst2),
        .OutDecodeInst3(OutDecodeInst3), .OutDecodeInst4(OutDecodeInst4),
        .OutDecodeMask(OutDecodeMask), .InDecodeReady(InDecodeReady),
        .OutQueueCount(OutQueueCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] pc, i1, i2, i3, i4;
        logic [3:0]  mask;
    } pkt_t;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic [3:0]  mask;
        logic        dr;
        logic        fl;
        int          exp_cnt;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [3:0]  exp_mask;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    pkt_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic pkt_t mk(input logic [31:0] pc, input logic [3:0] mask);
        pkt_t p;
        p.pc = pc; p.i1 = pc ^ 32'h11; p.i2 = pc ^ 32'h22;
        p.i3 = pc ^ 32'h33; p.i4 = pc ^ 32'h44; p.mask = mask;
        return p;
    endfunction

    task automatic drive(input logic fv, input pkt_t p, input logic dr, input logic fl);
        InFetchValid = fv; InFetchPc = p.pc;
        InFetchInst1 = p.i1; InFetchInst2 = p.i2; InFetchInst3 = p.i3; InFetchInst4 = p.i4;
        InFetchMask = p.mask; InDecodeReady = dr; InFlush = fl;
    endtask

    task automatic idle();
        drive(1'b0, mk(32'h0, 4'h0), 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        Rest = 1'b1;
        tick();
        Rest = 1'b0;
        mq.delete();
    endtask

    // Compare every output against the model's view of the queue.
    task automatic model_check(input string tag);
        pkt_t h;
        logic ev;
        ev = mq.size() != 0;
        h = mk(32'h0, 4'h0);
        h.i1 = 0; h.i2 = 0; h.i3 = 0; h.i4 = 0;
        if (ev) h = mq[0];
        chk({tag, ".valid"}, 32'(OutDecodeValid), 32'(ev));
        chk({tag, ".ready"}, 32'(OutFetchReady), 32'(mq.size() < DEPTH));
        chk({tag, ".count"}, 32'(OutQueueCount), 32'(mq.size()));
        chk({tag, ".pc"},    OutDecodePc,    h.pc);
        chk({tag, ".inst1"}, OutDecodeInst1, h.i1);
        chk({tag, ".inst2"}, OutDecodeInst2, h.i2);
        chk({tag, ".inst3"}, OutDecodeInst3, h.i3);
        chk({tag, ".inst4"}, OutDecodeInst4, h.i4);
        chk({tag, ".mask"},  OutDecodeMask,  h.mask);
    endtask

    // One clock with the model updated from the queue rules.
    task automatic model_cycle(input logic fv, input pkt_t p, input logic dr, input logic fl,
                               output logic pushed, output logic popped);
        logic ready_pre, valid_pre;
        ready_pre = mq.size() < DEPTH;
        valid_pre = mq.size() != 0;
        drive(fv, p, dr, fl);
        pushed = 1'b0;
        popped = 1'b0;
        tick();
        if (fl) begin
            mq.delete();
        end else begin
            if (valid_pre && dr) begin
                void'(mq.pop_front());
                popped = 1'b1;
            end
            if (fv && ready_pre && p.mask != 4'h0) begin
                mq.push_back(p);
                pushed = 1'b1;
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic pu, po;
        int   next_idx, pop_idx, cyc;
        pkt_t p;

        vecs[0] = '{1'b1, 32'h1C000000, 4'hF, 1'b0, 1'b0, 1, 1'b1, 32'h1C000000, 4'hF};
        vecs[1] = '{1'b1, 32'h1C000010, 4'h0, 1'b0, 1'b0, 1, 1'b1, 32'h1C000000, 4'hF};
        vecs[2] = '{1'b1, 32'h1C000020, 4'h3, 1'b0, 1'b0, 2, 1'b1, 32'h1C000000, 4'hF};
        vecs[3] = '{1'b1, 32'h1C000030, 4'hF, 1'b1, 1'b0, 2, 1'b1, 32'h1C000020, 4'h3};
        vecs[4] = '{1'b0, 32'h1C000040, 4'hF, 1'b1, 1'b0, 1, 1'b1, 32'h1C000030, 4'hF};
        vecs[5] = '{1'b1, 32'h1C000050, 4'hF, 1'b1, 1'b1, 0, 1'b0, 32'h0,        4'h0};
        vecs[6] = '{1'b0, 32'h1C000060, 4'hF, 1'b1, 1'b0, 0, 1'b0, 32'h0,        4'h0};
        vecs[7] = '{1'b1, 32'h1C000070, 4'h5, 1'b1, 1'b0, 1, 1'b1, 32'h1C000070, 4'h5};

        // Reset state, sampled while reset is still held.
        idle();
        Rest = 1'b1;
        #12;
        chk("rst.ready", 32'(OutFetchReady), 32'd1);
        chk("rst.valid", 32'(OutDecodeValid), 32'd0);
        chk("rst.count", 32'(OutQueueCount), 32'd0);
        chk("rst.pc", OutDecodePc, 32'd0);
        chk("rst.mask", 32'(OutDecodeMask), 32'd0);
        @(posedge Clk); #1;
        Rest = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].fv, mk(vecs[i].pc, vecs[i].mask), vecs[i].dr, vecs[i].fl);
            tick();
            chk($sformatf("vec%0d.count", i), 32'(OutQueueCount), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d.valid", i), 32'(OutDecodeValid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.pc", i), OutDecodePc, vecs[i].exp_pc);
            chk($sformatf("vec%0d.mask", i), 32'(OutDecodeMask), 32'(vecs[i].exp_mask));
        end

        // Single packet with explicit slot data; not visible before the edge.
        do_reset();
        p = '{32'h1C000000, 32'h11, 32'h22, 32'h33, 32'h44, 4'hF};
        drive(1'b1, p, 1'b0, 1'b0);
        #2;
        chk("lat.valid_before_edge", 32'(OutDecodeValid), 32'd0);
        tick();
        mq.push_back(p);
        idle();
        model_check("one");

        // Fill to full, reject ninth, then one pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) model_cycle(1'b1, mk(32'h2000 + 16*i, 4'hF), 1'b0, 1'b0, pu, po);
        chk("full.ready", 32'(OutFetchReady), 32'd0);
        chk("full.count", 32'(OutQueueCount), 32'd8);
        model_cycle(1'b1, mk(32'h2FF0, 4'hF), 1'b0, 1'b0, pu, po);
        chk("full.ninth_count", 32'(OutQueueCount), 32'd8);
        chk("full.head", OutDecodePc, 32'h2000);
        model_cycle(1'b0, mk(32'h0, 4'h0), 1'b1, 1'b0, pu, po);
        chk("full.pop_ready", 32'(OutFetchReady), 32'd1);
        chk("full.pop_count", 32'(OutQueueCount), 32'd7);
        model_check("full");

        // Count 3, simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 3; i++) model_cycle(1'b1, mk(32'h3000 + 16*i, 4'hF), 1'b0, 1'b0, pu, po);
        model_cycle(1'b1, mk(32'h3030, 4'hF), 1'b1, 1'b0, pu, po);
        chk("pp.count", 32'(OutQueueCount), 32'd3);
        chk("pp.head", OutDecodePc, 32'h3010);

        // Count 5, flush with push and pop offered; pre-flush flags during the cycle.
        do_reset();
        for (int i = 0; i < 5; i++) model_cycle(1'b1, mk(32'h4000 + 16*i, 4'hF), 1'b0, 1'b0, pu, po);
        drive(1'b1, mk(32'h4050, 4'hF), 1'b1, 1'b1);
        #2;
        chk("fl.pre_valid", 32'(OutDecodeValid), 32'd1);
        chk("fl.pre_count", 32'(OutQueueCount), 32'd5);
        tick();
        mq.delete();
        idle();
        model_check("fl");

        // Asynchronous reset mid-operation, then first push after release.
        do_reset();
        model_cycle(1'b1, mk(32'h5000, 4'hF), 1'b0, 1'b0, pu, po);
        model_cycle(1'b1, mk(32'h5010, 4'hF), 1'b0, 1'b0, pu, po);
        #2;
        Rest = 1'b1;
        #1;
        chk("arst.count", 32'(OutQueueCount), 32'd0);
        chk("arst.valid", 32'(OutDecodeValid), 32'd0);
        chk("arst.pc", OutDecodePc, 32'd0);
        @(posedge Clk); #1;
        Rest = 1'b0;
        mq.delete();
        model_cycle(1'b1, mk(32'h5020, 4'hF), 1'b0, 1'b0, pu, po);
        model_check("arst_after");

        // Stream 20 packets across pointer wrap with random decode backpressure.
        do_reset();
        next_idx = 0;
        pop_idx = 0;
        cyc = 0;
        while (pop_idx < 20 && cyc < 2000) begin
            p = mk(32'h1C000000 + 16*next_idx, 4'hF);
            p.i1 = $urandom; p.i2 = $urandom; p.i3 = $urandom; p.i4 = $urandom;
            if (OutDecodeValid && mq.size() != 0)
                chk("stream.order", OutDecodePc, 32'h1C000000 + 16*pop_idx);
            model_cycle(next_idx < 20, p, 1'($urandom_range(0, 1)), 1'b0, pu, po);
            if (pu) next_idx++;
            if (po) pop_idx++;
            model_check("stream");
            cyc++;
        end
        chk("stream.all_popped", 32'(pop_idx), 32'd20);

        // General random traffic: empty masks, occasional flushes.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            p.pc = $urandom; p.i1 = $urandom; p.i2 = $urandom; p.i3 = $urandom; p.i4 = $urandom;
            p.mask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            model_cycle(1'($urandom_range(0, 3) != 0), p, 1'($urandom_range(0, 2) == 0),
                        1'($urandom_range(0, 40) == 0), pu, po);
            model_check("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
